// File: rtl/cipher_bus_master.sv
// rtl/cipher_bus_master.sv - CipherBus requester: host block port, credit-limited issue to the AES core, response FIFO
module cipher_bus_master #(
    parameter int RSP_DEPTH      = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         resetL,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [127:0] req_data,
    input  logic         req_ende,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_data,
    output logic         rsp_ende,
    input  logic         clr_err,
    output logic         err_timeout,
    output logic         err_spurious,
    output logic         i_enable,
    output logic         i_ende,
    output logic [127:0] i_data,
    output logic         i_data_valid,
    input  logic         o_ready,
    input  logic         o_data_valid,
    input  logic [127:0] o_data
);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(RSP_DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, ERR} state_t;

    state_t        state_q;
    logic          cur_ende_q;
    logic          i_enable_q;
    logic          i_data_valid_q;
    logic [127:0]  i_data_q;
    logic          err_timeout_q;
    logic          err_spurious_q;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [TW-1:0] timer_q, timer_d;
    logic [128:0]  mem_q [RSP_DEPTH];
    logic [128:0]  head;

    logic credit_ok, issue, rsp_hit, spurious, push, pop, timeout_fire;

    assign rsp_hit      = o_data_valid && (outstanding_q != '0);
    assign spurious     = o_data_valid && (outstanding_q == '0);
    assign push         = rsp_hit;
    assign pop          = rsp_valid && rsp_ready;
    assign timeout_fire = (state_q != ERR) && (outstanding_q != '0) && !o_data_valid
                          && (timer_q == TMO_LAST);

    // Every outstanding op owns a FIFO slot, so a push can never find the FIFO full.
    assign credit_ok = ({1'b0, outstanding_q} + {1'b0, fifo_cnt_q}) < DEPTH_C;
    assign req_ready = (state_q == RUN) && req_valid && (req_ende == cur_ende_q) && o_ready
                       && !i_data_valid_q && credit_ok && !timeout_fire;
    assign issue     = req_ready;

    assign head         = mem_q[rd_ptr_q];
    assign rsp_valid    = (fifo_cnt_q != '0);
    assign rsp_data     = rsp_valid ? head[128:1] : '0;
    assign rsp_ende     = rsp_valid ? head[0] : 1'b0;
    assign err_timeout  = err_timeout_q;
    assign err_spurious = err_spurious_q;
    assign i_enable     = i_enable_q;
    assign i_ende       = cur_ende_q;
    assign i_data       = i_data_q;
    assign i_data_valid = i_data_valid_q;

    always_comb begin
        outstanding_d = outstanding_q;
        if (issue && !rsp_hit)
            outstanding_d = outstanding_q + 1'b1;
        else if (!issue && rsp_hit)
            outstanding_d = outstanding_q - 1'b1;

        fifo_cnt_d = fifo_cnt_q;
        if (push && !pop)
            fifo_cnt_d = fifo_cnt_q + 1'b1;
        else if (!push && pop)
            fifo_cnt_d = fifo_cnt_q - 1'b1;

        timer_d = timer_q;
        if (state_q != ERR)
            timer_d = ((outstanding_q == '0) || o_data_valid) ? '0 : timer_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= {o_data, cur_ende_q};
    end

    always_ff @(posedge clk or negedge resetL) begin
        if (!resetL) begin
            state_q        <= IDLE;
            cur_ende_q     <= 1'b0;
            i_enable_q     <= 1'b0;
            i_data_valid_q <= 1'b0;
            i_data_q       <= '0;
            err_timeout_q  <= 1'b0;
            err_spurious_q <= 1'b0;
            outstanding_q  <= '0;
            fifo_cnt_q     <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            timer_q        <= '0;
        end else begin
            i_enable_q     <= 1'b1;
            i_data_valid_q <= issue;
            if (issue)
                i_data_q <= req_data;
            outstanding_q <= outstanding_d;
            fifo_cnt_q    <= fifo_cnt_d;
            timer_q       <= timer_d;
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;

            if (clr_err) begin
                err_timeout_q  <= 1'b0;
                err_spurious_q <= 1'b0;
            end
            if (spurious)
                err_spurious_q <= 1'b1;

            if (timeout_fire) begin
                err_timeout_q <= 1'b1;
                state_q       <= ERR;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (req_valid) begin
                            state_q    <= RUN;
                            cur_ende_q <= req_ende;
                        end
                    end
                    RUN: begin
                        if (req_valid && (req_ende != cur_ende_q))
                            state_q <= DRAIN;
                        else if (!req_valid && (outstanding_q == '0))
                            state_q <= IDLE;
                    end
                    DRAIN: begin
                        // Mode flips only once every in-flight result of the old mode is back.
                        if (outstanding_q == '0) begin
                            state_q    <= RUN;
                            cur_ende_q <= req_ende;
                        end
                    end
                    ERR: begin
                        if (clr_err) begin
                            state_q       <= IDLE;
                            outstanding_q <= '0;
                            timer_q       <= '0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule
